// File: rtl/riscv_pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage RISC-V pipeline: branch/jump redirect, load-use and RAW stalls.
// Define HAZARD_FORWARD_EN to stall only on load-use hazards (forwarding datapath present).
module riscv_pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES      = 2,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int REG_W             = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ex_valid,
    input  logic [6:0]       ex_opcode,
    input  logic [2:0]       ex_func3,
    input  logic             ex_zero,
    input  logic             ex_lessThan,
    input  logic             ex_lessThanU,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_reg_write,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    output logic             pcSrc,
    output logic             flush,
    output logic             stall,
    output logic [1:0]       state
);

    localparam int CNT_W = 3;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(LOAD_STALL_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           cur_state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] next_count;

    logic run_valid;
    logic branch_taken;
    logic redirect;
    logic ex_match;
    logic mem_match;
    logic load_use;
    logic hazard;

    // x0 is hardwired to zero, so it never carries a dependency.
    assign ex_match  = (ex_rd != '0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    assign mem_match = (mem_rd != '0) &&
                       ((id_use_rs1 && (id_rs1 == mem_rd)) || (id_use_rs2 && (id_rs2 == mem_rd)));

    assign run_valid = ex_valid && (cur_state == RUN);

    always_comb begin
        branch_taken = 1'b0;
        case (ex_func3)
            3'b000:  branch_taken = ex_zero;
            3'b001:  branch_taken = !ex_zero;
            3'b100:  branch_taken = ex_lessThan;
            3'b101:  branch_taken = !ex_lessThan;
            3'b110:  branch_taken = ex_lessThanU;
            3'b111:  branch_taken = !ex_lessThanU;
            default: branch_taken = 1'b0;
        endcase
    end

    assign redirect = run_valid &&
                      ((ex_opcode == OP_JAL) || (ex_opcode == OP_JALR) ||
                       ((ex_opcode == OP_BRANCH) && branch_taken));

    assign load_use = run_valid && (ex_opcode == OP_LOAD) && ex_match;

`ifdef HAZARD_FORWARD_EN
    logic unused_raw_inputs;
    assign unused_raw_inputs = ^{mem_rd, mem_reg_write, ex_reg_write, mem_match};
    assign hazard = load_use;
`else
    // Without forwarding, any in-flight writer of a source register must drain first.
    assign hazard = load_use ||
                    (run_valid && ex_reg_write && ex_match) ||
                    ((cur_state == RUN) && mem_reg_write && mem_match);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= RUN;
            count     <= '0;
        end else begin
            cur_state <= next_state;
            count     <= next_count;
        end
    end

    // Redirect has priority over a stall; the counter holds remaining extra cycles.
    always_comb begin
        pcSrc      = 1'b0;
        flush      = 1'b0;
        stall      = 1'b0;
        next_state = cur_state;
        next_count = count;
        case (cur_state)
            RUN: begin
                if (redirect) begin
                    pcSrc = 1'b1;
                    flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        next_state = FLUSH;
                        next_count = FLUSH_LOAD;
                    end
                end else if (hazard) begin
                    stall = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        next_state = STALL;
                        next_count = STALL_LOAD;
                    end
                end
            end
            STALL: begin
                stall = 1'b1;
                if (count <= 1) begin
                    next_state = RUN;
                    next_count = '0;
                end else begin
                    next_count = count - 1'b1;
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (count <= 1) begin
                    next_state = RUN;
                    next_count = '0;
                end else begin
                    next_count = count - 1'b1;
                end
            end
            default: begin
                next_state = RUN;
                next_count = '0;
            end
        endcase
        if (!reset_n) begin
            pcSrc = 1'b0;
            flush = 1'b0;
            stall = 1'b0;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_riscv_pipeline_hazard_ctrl.sv
// Directed bench for riscv_pipeline_hazard_ctrl: default instance for the vector table,
// a LOAD_STALL_CYCLES=3 / FLUSH_CYCLES=3 instance for multi-cycle sequences.
module tb_riscv_pipeline_hazard_ctrl;

    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] LD   = 7'b0000011;
    localparam logic [6:0] ALU  = 7'b0110011;

`ifdef HAZARD_FORWARD_EN
    localparam logic NOFWD = 1'b0;
`else
    localparam logic NOFWD = 1'b1;
`endif

    typedef struct {
        string      name;
        logic       exValid;
        logic [6:0] opcode;
        logic [2:0] func3;
        logic       zero;
        logic       lt;
        logic       ltu;
        logic [4:0] exRd;
        logic       exRw;
        logic [4:0] memRd;
        logic       memRw;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic       expPc;
        logic       expFlush;
        logic       expStall;
        logic [1:0] expState;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic       exValid;
    logic [6:0] exOpcode;
    logic [2:0] exFunc3;
    logic       exZero;
    logic       exLessThan;
    logic       exLessThanU;
    logic [4:0] exRd;
    logic       exRegWrite;
    logic [4:0] memRd;
    logic       memRegWrite;
    logic [4:0] idRs1;
    logic [4:0] idRs2;
    logic       idUseRs1;
    logic       idUseRs2;

    logic       pcSrcA, flushA, stallA;
    logic [1:0] stateA;
    logic       pcSrcB, flushB, stallB;
    logic [1:0] stateB;

    int nChecks = 0;
    int nFails  = 0;
    vec_t vecs[$];
    vec_t idleV, ldUseV, beqV, jalV;

    riscv_pipeline_hazard_ctrl dutA (
        .clk(clk), .reset_n(reset_n), .ex_valid(exValid), .ex_opcode(exOpcode),
        .ex_func3(exFunc3), .ex_zero(exZero), .ex_lessThan(exLessThan),
        .ex_lessThanU(exLessThanU), .ex_rd(exRd), .ex_reg_write(exRegWrite),
        .mem_rd(memRd), .mem_reg_write(memRegWrite), .id_rs1(idRs1), .id_rs2(idRs2),
        .id_use_rs1(idUseRs1), .id_use_rs2(idUseRs2),
        .pcSrc(pcSrcA), .flush(flushA), .stall(stallA), .state(stateA)
    );

    riscv_pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .LOAD_STALL_CYCLES(3)) dutB (
        .clk(clk), .reset_n(reset_n), .ex_valid(exValid), .ex_opcode(exOpcode),
        .ex_func3(exFunc3), .ex_zero(exZero), .ex_lessThan(exLessThan),
        .ex_lessThanU(exLessThanU), .ex_rd(exRd), .ex_reg_write(exRegWrite),
        .mem_rd(memRd), .mem_reg_write(memRegWrite), .id_rs1(idRs1), .id_rs2(idRs2),
        .id_use_rs1(idUseRs1), .id_use_rs2(idUseRs2),
        .pcSrc(pcSrcB), .flush(flushB), .stall(stallB), .state(stateB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(string n, logic ev, logic [6:0] op, logic [2:0] f3,
                                logic z, logic lt, logic ltu, logic [4:0] erd, logic erw,
                                logic [4:0] mrd, logic mrw, logic [4:0] r1, logic [4:0] r2,
                                logic u1, logic u2, logic ep, logic ef, logic es,
                                logic [1:0] est);
        vec_t v;
        v.name = n; v.exValid = ev; v.opcode = op; v.func3 = f3;
        v.zero = z; v.lt = lt; v.ltu = ltu; v.exRd = erd; v.exRw = erw;
        v.memRd = mrd; v.memRw = mrw; v.rs1 = r1; v.rs2 = r2; v.use1 = u1; v.use2 = u2;
        v.expPc = ep; v.expFlush = ef; v.expStall = es; v.expState = est;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        exValid = v.exValid; exOpcode = v.opcode; exFunc3 = v.func3;
        exZero = v.zero; exLessThan = v.lt; exLessThanU = v.ltu;
        exRd = v.exRd; exRegWrite = v.exRw; memRd = v.memRd; memRegWrite = v.memRw;
        idRs1 = v.rs1; idRs2 = v.rs2; idUseRs1 = v.use1; idUseRs2 = v.use2;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    initial begin
        idleV  = mk("idle", 0, 7'd0, 3'd0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 2'd0);
        ldUseV = mk("lduse", 1, LD, 3'd2, 0, 0, 0, 5'd5, 1, 5'd0, 0, 5'd0, 5'd5, 0, 1, 0, 0, 1, 2'd0);
        beqV   = mk("beq", 1, BR, 3'd0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd1, 5'd2, 1, 1, 1, 1, 0, 2'd2);
        jalV   = mk("jal", 1, JAL, 3'd0, 0, 0, 0, 5'd1, 1, 5'd0, 0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 2'd2);

        vecs.push_back(idleV);
        vecs.push_back(beqV);
        vecs.push_back(mk("beq_nt", 1, BR, 3'd0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd1, 5'd2, 1, 1, 0, 0, 0, 2'd0));
        vecs.push_back(mk("bne_t", 1, BR, 3'd1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd1, 5'd2, 1, 1, 1, 1, 0, 2'd2));
        vecs.push_back(mk("bltu_t", 1, BR, 3'd6, 0, 0, 1, 5'd0, 0, 5'd0, 0, 5'd1, 5'd2, 1, 1, 1, 1, 0, 2'd2));
        vecs.push_back(mk("blt_nt", 1, BR, 3'd4, 0, 0, 1, 5'd0, 0, 5'd0, 0, 5'd1, 5'd2, 1, 1, 0, 0, 0, 2'd0));
        vecs.push_back(mk("bge_t", 1, BR, 3'd5, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd1, 5'd2, 1, 1, 1, 1, 0, 2'd2));
        vecs.push_back(mk("bgeu_nt", 1, BR, 3'd7, 0, 0, 1, 5'd0, 0, 5'd0, 0, 5'd1, 5'd2, 1, 1, 0, 0, 0, 2'd0));
        vecs.push_back(mk("br_f3_010", 1, BR, 3'd2, 1, 1, 1, 5'd0, 0, 5'd0, 0, 5'd1, 5'd2, 1, 1, 0, 0, 0, 2'd0));
        vecs.push_back(jalV);
        vecs.push_back(mk("jalr", 1, JALR, 3'd0, 0, 0, 0, 5'd3, 1, 5'd0, 0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 2'd2));
        vecs.push_back(mk("jal_invalid", 0, JAL, 3'd0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 2'd0));
        vecs.push_back(ldUseV);
        vecs.push_back(mk("lduse_x0", 1, LD, 3'd2, 0, 0, 0, 5'd0, 1, 5'd0, 0, 5'd0, 5'd0, 1, 1, 0, 0, 0, 2'd0));
        vecs.push_back(mk("lduse_unused", 1, LD, 3'd2, 0, 0, 0, 5'd5, 1, 5'd0, 0, 5'd0, 5'd5, 0, 0, 0, 0, 0, 2'd0));
        vecs.push_back(mk("lduse_rs1", 1, LD, 3'd2, 0, 0, 0, 5'd5, 1, 5'd0, 0, 5'd5, 5'd0, 1, 0, 0, 0, 1, 2'd0));
        vecs.push_back(mk("raw_ex", 1, ALU, 3'd0, 0, 0, 0, 5'd7, 1, 5'd0, 0, 5'd7, 5'd0, 1, 0, 0, 0, NOFWD, 2'd0));
        vecs.push_back(mk("raw_mem", 0, 7'd0, 3'd0, 0, 0, 0, 5'd0, 0, 5'd9, 1, 5'd0, 5'd9, 0, 1, 0, 0, NOFWD, 2'd0));
        vecs.push_back(mk("raw_mem_x0", 0, 7'd0, 3'd0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 5'd0, 5'd0, 1, 1, 0, 0, 0, 2'd0));
        vecs.push_back(mk("br_and_raw", 1, BR, 3'd0, 1, 0, 0, 5'd0, 0, 5'd4, 1, 5'd4, 5'd0, 1, 0, 1, 1, 0, 2'd2));

        // Asynchronous reset with a taken jump sitting in EX.
        applyStimulus(jalV);
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        checkOutput("rst_pcSrcA", int'(pcSrcA), 0);
        checkOutput("rst_flushA", int'(flushA), 0);
        checkOutput("rst_stallA", int'(stallA), 0);
        checkOutput("rst_stateA", int'(stateA), 0);
        checkOutput("rst_flushB", int'(flushB), 0);
        checkOutput("rst_stateB", int'(stateB), 0);
        @(negedge clk);
        applyStimulus(idleV);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput({vecs[i].name, "/pcSrc"}, int'(pcSrcA), int'(vecs[i].expPc));
            checkOutput({vecs[i].name, "/flush"}, int'(flushA), int'(vecs[i].expFlush));
            checkOutput({vecs[i].name, "/stall"}, int'(stallA), int'(vecs[i].expStall));
            @(negedge clk);
            #1;
            checkOutput({vecs[i].name, "/state"}, int'(stateA), int'(vecs[i].expState));
            applyStimulus(idleV);
            repeat (3) @(negedge clk);
        end

        // BEQ taken on the default instance: flush held one extra cycle, pcSrc only first.
        @(negedge clk);
        applyStimulus(beqV);
        #1;
        checkOutput("seqbeq_n_pcSrc", int'(pcSrcA), 1);
        checkOutput("seqbeq_n_flush", int'(flushA), 1);
        checkOutput("seqbeq_n_state", int'(stateA), 0);
        @(negedge clk);
        #1;
        checkOutput("seqbeq_n1_pcSrc", int'(pcSrcA), 0);
        checkOutput("seqbeq_n1_flush", int'(flushA), 1);
        checkOutput("seqbeq_n1_stall", int'(stallA), 0);
        checkOutput("seqbeq_n1_state", int'(stateA), 2);
        @(negedge clk);
        applyStimulus(idleV);
        #1;
        checkOutput("seqbeq_n2_flush", int'(flushA), 0);
        checkOutput("seqbeq_n2_state", int'(stateA), 0);

        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Three-cycle load-use stall; a taken branch arriving mid-stall is ignored.
        @(negedge clk);
        applyStimulus(ldUseV);
        #1;
        checkOutput("seqst_n_stall", int'(stallB), 1);
        checkOutput("seqst_n_state", int'(stateB), 0);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            applyStimulus(beqV);
            #1;
            checkOutput($sformatf("seqst_n%0d_stall", k), int'(stallB), 1);
            checkOutput($sformatf("seqst_n%0d_pcSrc", k), int'(pcSrcB), 0);
            checkOutput($sformatf("seqst_n%0d_flush", k), int'(flushB), 0);
            checkOutput($sformatf("seqst_n%0d_state", k), int'(stateB), 1);
        end
        @(negedge clk);
        applyStimulus(idleV);
        #1;
        checkOutput("seqst_n3_stall", int'(stallB), 0);
        checkOutput("seqst_n3_state", int'(stateB), 0);

        // Three-cycle flush; a load-use hazard during flush raises no stall.
        @(negedge clk);
        applyStimulus(jalV);
        #1;
        checkOutput("seqfl_n_pcSrc", int'(pcSrcB), 1);
        checkOutput("seqfl_n_flush", int'(flushB), 1);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            applyStimulus(ldUseV);
            #1;
            checkOutput($sformatf("seqfl_n%0d_flush", k), int'(flushB), 1);
            checkOutput($sformatf("seqfl_n%0d_stall", k), int'(stallB), 0);
            checkOutput($sformatf("seqfl_n%0d_pcSrc", k), int'(pcSrcB), 0);
            checkOutput($sformatf("seqfl_n%0d_state", k), int'(stateB), 2);
        end
        @(negedge clk);
        applyStimulus(idleV);
        #1;
        checkOutput("seqfl_n3_flush", int'(flushB), 0);
        checkOutput("seqfl_n3_state", int'(stateB), 0);

        // Reset in the middle of a stall aborts it.
        @(negedge clk);
        applyStimulus(ldUseV);
        @(negedge clk);
        applyStimulus(idleV);
        #1;
        checkOutput("rststall_pre_state", int'(stateB), 1);
        reset_n = 1'b0;
        #1;
        checkOutput("rststall_state", int'(stateB), 0);
        checkOutput("rststall_stall", int'(stallB), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("rststall_post_state", int'(stateB), 0);
        checkOutput("rststall_post_stall", int'(stallB), 0);

        // Reset in the middle of a flush aborts it.
        @(negedge clk);
        applyStimulus(jalV);
        @(negedge clk);
        applyStimulus(idleV);
        #1;
        checkOutput("rstflush_pre_state", int'(stateB), 2);
        reset_n = 1'b0;
        #1;
        checkOutput("rstflush_state", int'(stateB), 0);
        checkOutput("rstflush_flush", int'(flushB), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("rstflush_post_state", int'(stateB), 0);
        checkOutput("rstflush_post_flush", int'(flushB), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
